// File: rtl/dso_acq_ctrl.sv
// Oscilloscope acquisition sequencer: pre-trigger fill, armed wait, post-trigger fill.
// Latency: wr_en is combinational from sample_en; state, addresses and trig_clr update one clk later.
// Backpressure: none; every sample_en strobe in PRE/ARMED/POST is written unconditionally.
//
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   start, abort          - one-cycle control pulses (abort wins over start and trigger)
//   pre_len, post_len     - sample counts before/after trigger, latched on an accepted start
//   sample_en             - sample strobe from the capture path
//   trig_sta, force_trig  - trigger level / software trigger, only honoured while ARMED
//   trig_clr              - registered clear to the trigger block (low while ARMED/POST)
//   wr_en, wr_addr        - sample-buffer write strobe and address
//   trig_addr             - buffer address of the sample taken in the trigger-detect cycle
//   busy, done            - acquisition in progress / acquisition complete
module dso_acq_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              sample_en,
  input  logic              trig_sta,
  input  logic              force_trig,
  output logic              trig_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_pre_len;
  logic [ADDR_W-1:0] r_post_len;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic              r_trig_clr;
  logic              w_active;
  logic              w_trig;

  assign w_active  = (r_state == S_PRE) | (r_state == S_ARMED) | (r_state == S_POST);
  assign wr_en     = sample_en & w_active;
  assign w_cnt_inc = r_cnt + ADDR_W'(1);
  assign w_trig    = trig_sta | force_trig;

  // Counters compare the value they are about to take, so the move out of
  // PRE/POST happens on the cycle after the final sample is written.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) w_state_nxt = (pre_len != '0) ? S_PRE : S_ARMED;
        end
        S_PRE: begin
          if (wr_en && (w_cnt_inc == r_pre_len)) w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (w_trig) w_state_nxt = (r_post_len != '0) ? S_POST : S_DONE;
        end
        S_POST: begin
          if (wr_en && (w_cnt_inc == r_post_len)) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_trig_addr <= '0;
      r_cnt       <= '0;
      r_pre_len   <= '0;
      r_post_len  <= '0;
      r_trig_clr  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // Trigger block is held clear everywhere except while we are waiting
      // for, or filling after, a trigger.
      r_trig_clr <= !((w_state_nxt == S_ARMED) || (w_state_nxt == S_POST));

      if (wr_en) r_wr_addr <= r_wr_addr + ADDR_W'(1);

      if (!abort) begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_pre_len  <= pre_len;
              r_post_len <= post_len;
              r_wr_addr  <= '0;
              r_cnt      <= '0;
            end
          end
          S_PRE: begin
            if (wr_en) r_cnt <= w_cnt_inc;
          end
          S_ARMED: begin
            // The sample written in this cycle (if any) lands at the
            // pre-increment address and belongs to the pre-trigger record.
            if (w_trig) begin
              r_trig_addr <= r_wr_addr;
              r_cnt       <= '0;
            end
          end
          S_POST: begin
            if (wr_en) r_cnt <= w_cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_addr   = r_wr_addr;
  assign trig_addr = r_trig_addr;
  assign trig_clr  = r_trig_clr;
  assign busy      = w_active;
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Testbench for dso_acq_ctrl: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs compared 1 time unit after each falling edge.
// Backpressure: not applicable.
module tb_dso_acq_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] pre_len;
  logic [ADDR_W-1:0] post_len;
  logic              sample_en;
  logic              trig_sta;
  logic              force_trig;
  logic              trig_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic              done;

  dso_acq_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pre_len    (pre_len),
    .post_len   (post_len),
    .sample_en  (sample_en),
    .trig_sta   (trig_sta),
    .force_trig (force_trig),
    .trig_clr   (trig_clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .trig_addr  (trig_addr),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: acquisition phase plus remaining-sample countdowns.
  typedef enum int {P_IDLE, P_PRE, P_ARMED, P_POST, P_DONE} phase_t;
  phase_t m_ph;
  int     m_addr;
  int     m_trig;
  int     m_pre_left;
  int     m_post_len;
  int     m_post_left;

  task automatic model_reset();
    m_ph        = P_IDLE;
    m_addr      = 0;
    m_trig      = 0;
    m_pre_left  = 0;
    m_post_len  = 0;
    m_post_left = 0;
  endtask

  task automatic model_update(input bit we);
    int old_addr;
    old_addr = m_addr;
    if (rst) begin
      model_reset();
    end else begin
      if (we) m_addr = (m_addr + 1) % DEPTH;
      if (abort) begin
        m_ph = P_IDLE;
      end else begin
        case (m_ph)
          P_IDLE, P_DONE: begin
            if (start) begin
              m_addr     = 0;
              m_pre_left = int'(pre_len);
              m_post_len = int'(post_len);
              m_ph       = (m_pre_left > 0) ? P_PRE : P_ARMED;
            end
          end
          P_PRE: begin
            if (we) begin
              m_pre_left--;
              if (m_pre_left == 0) m_ph = P_ARMED;
            end
          end
          P_ARMED: begin
            if (trig_sta || force_trig) begin
              m_trig      = old_addr;
              m_post_left = m_post_len;
              m_ph        = (m_post_left > 0) ? P_POST : P_DONE;
            end
          end
          P_POST: begin
            if (we) begin
              m_post_left--;
              if (m_post_left == 0) m_ph = P_DONE;
            end
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  endtask

  // One clock cycle: compare all outputs against the model, advance the model,
  // then wait for the next falling edge where new inputs are applied.
  task automatic step();
    bit exp_we;
    bit exp_busy;
    #1;
    exp_busy = (m_ph == P_PRE) || (m_ph == P_ARMED) || (m_ph == P_POST);
    exp_we   = sample_en && exp_busy;
    check_eq("wr_en",     int'(wr_en),     int'(exp_we));
    check_eq("wr_addr",   int'(wr_addr),   m_addr);
    check_eq("trig_addr", int'(trig_addr), m_trig);
    check_eq("busy",      int'(busy),      int'(exp_busy));
    check_eq("done",      int'(done),      int'(m_ph == P_DONE));
    check_eq("trig_clr",  int'(trig_clr),
             int'((m_ph == P_IDLE) || (m_ph == P_PRE) || (m_ph == P_DONE)));
    model_update(exp_we);
    @(negedge clk);
  endtask

  task automatic quiet();
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    trig_sta   = 1'b0;
    force_trig = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    quiet();
    rst       = 1'b1;
    sample_en = 1'b0;
    pre_len   = '0;
    post_len  = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    step();                         // reset-state comparison with rst still high
    quiet();
    step();

    // pre=3, post=2, trigger on the second ARMED cycle
    sample_en = 1'b1;
    pre_len   = ADDR_W'(3);
    post_len  = ADDR_W'(2);
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    step();
    trig_sta = 1'b1;
    step();
    trig_sta = 1'b0;
    repeat (2) step();
    step();                         // DONE must hold addresses despite sample_en
    #1;
    check_eq("s1_done",      int'(done),      1);
    check_eq("s1_wr_addr",   int'(wr_addr),   7);
    check_eq("s1_trig_addr", int'(trig_addr), 4);

    // pre=0, post=0, forced trigger
    pre_len  = '0;
    post_len = '0;
    start    = 1'b1;
    step();
    start      = 1'b0;
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    #1;
    check_eq("s2_done",      int'(done),      1);
    check_eq("s2_trig_addr", int'(trig_addr), 0);
    check_eq("s2_wr_addr",   int'(wr_addr),   1);
    step();

    // no trigger for 20 samples: address wraps while ARMED
    pre_len  = ADDR_W'(2);
    post_len = ADDR_W'(3);
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    #1;
    check_eq("s3_busy",     int'(busy),     1);
    check_eq("s3_trig_clr", int'(trig_clr), 0);
    check_eq("s3_wr_addr",  int'(wr_addr),  4);

    // abort and trigger together in ARMED
    abort    = 1'b1;
    trig_sta = 1'b1;
    step();
    quiet();
    #1;
    check_eq("s4_done",      int'(done),      0);
    check_eq("s4_busy",      int'(busy),      0);
    check_eq("s4_trig_clr",  int'(trig_clr),  1);
    check_eq("s4_trig_addr", int'(trig_addr), 0);
    step();

    // reset during POST with sample_en held high
    pre_len  = ADDR_W'(1);
    post_len = ADDR_W'(5);
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("s5_wr_en",     int'(wr_en),     0);
    check_eq("s5_wr_addr",   int'(wr_addr),   0);
    check_eq("s5_trig_addr", int'(trig_addr), 0);
    check_eq("s5_trig_clr",  int'(trig_clr),  1);
    check_eq("s5_busy",      int'(busy),      0);
    check_eq("s5_done",      int'(done),      0);
    step();

    // trigger level high throughout PRE is ignored until ARMED
    pre_len  = ADDR_W'(4);
    post_len = ADDR_W'(1);
    trig_sta = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #1;
    check_eq("s6_trig_addr_pre", int'(trig_addr), 0);
    step();
    #1;
    check_eq("s6_trig_addr", int'(trig_addr), 4);
    check_eq("s6_busy",      int'(busy),      1);
    step();
    quiet();
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(299) == 0);
      start      = ($urandom_range(15) == 0);
      abort      = ($urandom_range(79) == 0);
      sample_en  = ($urandom_range(9) < 7);
      trig_sta   = ($urandom_range(11) == 0);
      force_trig = ($urandom_range(39) == 0);
      pre_len    = ADDR_W'($urandom_range(DEPTH - 1));
      post_len   = ADDR_W'($urandom_range(DEPTH - 1));
      if ($urandom_range(3) == 0) pre_len = '0;
      if ($urandom_range(3) == 0) post_len = '0;
      step();
    end
    quiet();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
